// File: rtl/phasemeter_acq_ctrl.sv
// phasemeter_acq_ctrl: sweeps the NCO guess, detects carrier, enables the PI loop and tracks lock for one phasemeter channel
module phasemeter_acq_ctrl #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned F_START = 300000000,
  parameter int unsigned F_STOP = 380000000,
  parameter int unsigned F_STEP = 1000000,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned SETTLE = 8,
  parameter int unsigned DWELL = 32,
  parameter int unsigned LOCK_THRESH = 2048,
  parameter int unsigned I_THRESH = 256,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned UNLOCK_COUNT = 8,
  parameter int unsigned ACQ_TIMEOUT = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_I_tdata,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_Q_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_GUESS_tdata,
  output logic                        M_AXIS_GUESS_tvalid,
  output logic                        pm_rst,
  output logic                        loop_en,
  output logic                        locked,
  output logic [2:0]                  state,
  output logic [15:0]                 sweep_wraps,
  output logic [15:0]                 lock_losses
);
  localparam int W = AXIS_TDATA_WIDTH;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SEARCH, S_ACQUIRE, S_LOCKED} st_t;
  st_t st;
  logic [W-1:0] guess, ai, aq, ng;
  logic [W:0] nx;
  logic [31:0] cnt, hits, run, tmo, hn, rg, rb;
  logic [15:0] nw;
  logic hit, good, wrap;
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return !x[W-1] ? x : x == {1'b1, {(W-1){1'b0}}} ? {1'b0, {(W-1){1'b1}}} : -x;
  endfunction
  always_comb begin
    ai = mag(S_AXIS_I_tdata);
    aq = mag(S_AXIS_Q_tdata);
    hit = aq >= W'(LOCK_THRESH);
    good = hit && ai <= W'(I_THRESH);
    hn = hits + 32'(hit);
    rg = good ? run + 1 : 0;
    rb = good ? 0 : run + 1;
    nx = {1'b0, guess} + (W+1)'(F_STEP);
    wrap = nx[W] || nx[W-1:0] > W'(F_STOP);
    ng = wrap ? W'(F_START) : nx[W-1:0];
    nw = sweep_wraps + 16'(wrap && ~&sweep_wraps);
  end
  assign state = st;
  assign M_AXIS_GUESS_tdata = guess;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      guess <= W'(F_START);
      M_AXIS_GUESS_tvalid <= 1'b0;
      pm_rst <= 1'b1;
      loop_en <= 1'b0;
      locked <= 1'b0;
      sweep_wraps <= '0;
      lock_losses <= '0;
      {cnt, hits, run, tmo} <= '0;
    end else begin
      M_AXIS_GUESS_tvalid <= 1'b1;
      if (stop) begin
        st <= S_IDLE;
        pm_rst <= 1'b1;
        loop_en <= 1'b0;
        locked <= 1'b0;
        {cnt, hits, run, tmo} <= '0;
      end else begin
        case (st)
          S_IDLE: if (start) begin
            st <= S_LOAD;
            {cnt, hits, run, tmo} <= '0;
          end
          S_LOAD: if (cnt == RST_CYCLES - 1) begin
            st <= S_SETTLE;
            pm_rst <= 1'b0;
            cnt <= '0;
          end else cnt <= cnt + 1;
          S_SETTLE: if (S_AXIS_tvalid) begin
            if (cnt == SETTLE - 1) begin
              st <= S_SEARCH;
              cnt <= '0;
            end else cnt <= cnt + 1;
          end
          S_SEARCH: if (S_AXIS_tvalid) begin
            if (cnt == DWELL - 1) begin
              {cnt, hits, run, tmo} <= '0;
              if (hn >= DWELL / 2) begin
                st <= S_ACQUIRE;
                loop_en <= 1'b1;
              end else begin
                st <= S_LOAD;
                pm_rst <= 1'b1;
                guess <= ng;
                sweep_wraps <= nw;
              end
            end else begin
              cnt <= cnt + 1;
              hits <= hn;
            end
          end
          S_ACQUIRE: if (S_AXIS_tvalid) begin
            if (rg == LOCK_COUNT) begin
              st <= S_LOCKED;
              locked <= 1'b1;
              {cnt, hits, run, tmo} <= '0;
            end else if (tmo == ACQ_TIMEOUT - 1) begin
              st <= S_LOAD;
              pm_rst <= 1'b1;
              loop_en <= 1'b0;
              guess <= ng;
              sweep_wraps <= nw;
              {cnt, hits, run, tmo} <= '0;
            end else begin
              run <= rg;
              tmo <= tmo + 1;
            end
          end
          S_LOCKED: if (S_AXIS_tvalid) begin
            if (rb == UNLOCK_COUNT) begin
              st <= S_LOAD;
              pm_rst <= 1'b1;
              loop_en <= 1'b0;
              locked <= 1'b0;
              lock_losses <= lock_losses + 16'(~&lock_losses);
              {cnt, hits, run, tmo} <= '0;
            end else run <= rb;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_phasemeter_acq_ctrl.sv
// tb_phasemeter_acq_ctrl: randomized directed bench for phasemeter_acq_ctrl against a rule-level model
module tb_phasemeter_acq_ctrl;
  logic clk = 0, rst = 1, start = 0, stop = 0, tv = 0;
  logic [31:0] si = 0, sq = 0, guess;
  logic gv, pm_rst, loop_en, locked;
  logic [2:0] state;
  logic [15:0] wraps, losses;
  int checks = 0, errors = 0;
  longint eg = 100;
  int ew = 0, el = 0;
  always #5 clk = ~clk;
  phasemeter_acq_ctrl #(
    .AXIS_TDATA_WIDTH(32), .F_START(100), .F_STOP(130), .F_STEP(10), .RST_CYCLES(3),
    .SETTLE(2), .DWELL(4), .LOCK_THRESH(1000), .I_THRESH(200), .LOCK_COUNT(3),
    .UNLOCK_COUNT(2), .ACQ_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .S_AXIS_I_tdata(si), .S_AXIS_Q_tdata(sq), .S_AXIS_tvalid(tv),
    .M_AXIS_GUESS_tdata(guess), .M_AXIS_GUESS_tvalid(gv),
    .pm_rst(pm_rst), .loop_en(loop_en), .locked(locked), .state(state),
    .sweep_wraps(wraps), .lock_losses(losses)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] sv(input int unsigned lo, input int unsigned hi);
    int unsigned m;
    m = $urandom_range(hi, lo);
    return ($urandom_range(1, 0) != 0) ? -m : m;
  endfunction
  task automatic samp(input logic [31:0] i, input logic [31:0] q);
    repeat ($urandom_range(2, 0)) tick;
    si = i;
    sq = q;
    tv = 1;
    tick;
    tv = 0;
    si = $urandom;
    sq = $urandom;
  endtask
  task automatic model_step;
    longint n;
    n = eg + 10;
    if (n > 130 || n > 64'hFFFF_FFFF) begin
      eg = 100;
      ew++;
    end else eg = n;
  endtask
  task automatic retune;
    int n;
    n = 0;
    while (pm_rst === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    chk("pm_rst_len", n, 3);
    chk("settle_state", state, 2);
    chk("guess_stable", guess, eg);
  endtask
  task automatic search(input int nhit, input bit mn);
    bit f[4];
    samp($urandom, $urandom);
    samp($urandom, $urandom);
    chk("search_state", state, 3);
    chk("search_loop_en", loop_en, 0);
    for (int k = 0; k < 4; k++) f[k] = k < nhit;
    for (int k = 3; k > 0; k--) begin
      int j;
      bit t;
      j = $urandom_range(k, 0);
      t = f[k];
      f[k] = f[j];
      f[j] = t;
    end
    for (int k = 0; k < 4; k++)
      samp($urandom, f[k] ? (mn ? 32'h8000_0000 : sv(1000, 32'h7FFF_FFFF)) : sv(0, 999));
    if (nhit >= 2) begin
      chk("acq_state", state, 4);
      chk("acq_loop_en", loop_en, 1);
      chk("acq_guess", guess, eg);
    end else begin
      model_step();
      chk("step_state", state, 1);
      chk("step_guess", guess, eg);
      chk("step_wraps", wraps, ew);
      chk("step_loop_en", loop_en, 0);
      retune();
    end
  endtask
  task automatic good(input int n);
    repeat (n) samp(sv(0, 200), sv(1000, 32'h7FFF_FFFF));
  endtask
  task automatic bad;
    if ($urandom_range(1, 0) != 0) samp(sv(0, 32'h7FFF_FFFF), sv(0, 999));
    else samp(sv(201, 32'h7FFF_FFFF), sv(1000, 32'h7FFF_FFFF));
  endtask
  task automatic lock_seq;
    good(2);
    chk("pre_lock_state", state, 4);
    good(1);
    chk("lock_state", state, 5);
    chk("lock_locked", locked, 1);
    chk("lock_loop_en", loop_en, 1);
    chk("lock_guess", guess, eg);
  endtask
  task automatic lose;
    bad;
    chk("hold_lock", state, 5);
    bad;
    el++;
    chk("lose_state", state, 1);
    chk("lose_locked", locked, 0);
    chk("lose_loop_en", loop_en, 0);
    chk("lose_count", losses, el);
    chk("lose_guess", guess, eg);
    retune();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick;
    chk("rst_state", state, 0);
    chk("rst_guess", guess, 100);
    chk("rst_gv", gv, 0);
    chk("rst_pm_rst", pm_rst, 1);
    chk("rst_loop_en", loop_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_wraps", wraps, 0);
    chk("rst_losses", losses, 0);
    rst = 0;
    tick;
    chk("gv_after_rst", gv, 1);
    chk("idle_state", state, 0);
    start = 1;
    tick;
    start = 0;
    chk("start_load", state, 1);
    chk("start_guess", guess, 100);
    retune();
    repeat (4) search($urandom_range(1, 0), 0);
    chk("t1_guess", guess, 100);
    chk("t1_wraps", wraps, 1);
    repeat (2) search($urandom_range(1, 0), 0);
    search($urandom_range(4, 2), 0);
    chk("t2_guess", guess, 120);
    samp(50, 1500);
    samp(-32'sd200, 1000);
    samp(201, 1500);
    chk("t2_bad_i", state, 4);
    samp(200, -32'sd1000);
    samp(-32'sd50, 1500);
    chk("t2_two_good", state, 4);
    samp(0, 32'h7FFF_FFFF);
    chk("t2_locked_state", state, 5);
    chk("t2_locked", locked, 1);
    chk("t2_locked_guess", guess, 120);
    start = 1;
    tick;
    start = 0;
    chk("t3_start_ignored", state, 5);
    samp(50, 500);
    samp(50, 1500);
    samp(50, 999);
    chk("t3_bad_reset", state, 5);
    samp(50, -32'sd500);
    el++;
    chk("t3_lose_state", state, 1);
    chk("t3_locked", locked, 0);
    chk("t3_losses", losses, 1);
    chk("t3_guess", guess, 120);
    retune();
    search($urandom_range(4, 2), 0);
    lock_seq();
    lose();
    search($urandom_range(4, 2), 0);
    repeat (7) samp(($urandom_range(1, 0) != 0) ? 32'd300 : sv(201, 32'h7FFF_FFFF), 1500);
    chk("t4_pre_timeout", state, 4);
    samp(300, 1500);
    model_step();
    chk("t4_timeout_state", state, 1);
    chk("t4_timeout_guess", guess, 130);
    chk("t4_loop_en", loop_en, 0);
    retune();
    search($urandom_range(4, 2), 0);
    repeat (8) samp(sv(201, 32'h7FFF_FFFF), sv(1000, 32'h7FFF_FFFF));
    model_step();
    chk("t4_wrap_guess", guess, 100);
    chk("t4_wraps", wraps, 2);
    retune();
    search($urandom_range(4, 2), 0);
    repeat (5) bad;
    good(2);
    chk("t4_pre_coincide", state, 4);
    good(1);
    chk("t4_coincide", state, 5);
    chk("t4_coincide_guess", guess, 100);
    lose();
    search(2, 1);
    samp(32'h8000_0000, 32'h8000_0000);
    chk("t5_min_i_bad", state, 4);
    repeat (3) samp(sv(0, 200), 32'h8000_0000);
    chk("t5_min_q_lock", state, 5);
    bad;
    bad;
    el++;
    chk("t5_load", state, 1);
    tick;
    chk("t5_mid_load", state, 1);
    stop = 1;
    tick;
    stop = 0;
    chk("t5_stop_state", state, 0);
    chk("t5_stop_pm_rst", pm_rst, 1);
    chk("t5_stop_loop_en", loop_en, 0);
    chk("t5_stop_locked", locked, 0);
    chk("t5_stop_guess", guess, eg);
    repeat (5) tick;
    chk("t5_idle_hold", state, 0);
    chk("t5_losses", losses, el);
    start = 1;
    tick;
    start = 0;
    chk("t6_start", state, 1);
    retune();
    search($urandom_range(1, 0), 0);
    search($urandom_range(4, 2), 0);
    lock_seq();
    chk("t6_guess", guess, 110);
    rst = 1;
    tick;
    chk("t6_rst_state", state, 0);
    chk("t6_rst_guess", guess, 100);
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_wraps", wraps, 0);
    chk("t6_rst_losses", losses, 0);
    chk("t6_rst_gv", gv, 0);
    chk("t6_rst_pm_rst", pm_rst, 1);
    chk("t6_rst_loop_en", loop_en, 0);
    rst = 0;
    tick;
    start = 1;
    stop = 1;
    tick;
    start = 0;
    stop = 0;
    chk("t6_start_stop", state, 0);
    repeat (3) tick;
    chk("t6_idle", state, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
